tx_bit_stuffer: RTL and testbench
=================================

TX_BIT_STUFFER -- requirements
Module: tx_bit_stuffer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 8: clock cycles per USB bit period.
REQ-002 clk  in  1  system clock; all logic on its rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 tx_byte  in  8  byte to transmit, LSB first.
REQ-005 byte_valid  in  1  tx_byte is valid.
REQ-006 last_byte  in  1  qualifies tx_byte as the final byte of the packet.
REQ-007 byte_ready  out  1  block accepts tx_byte this cycle.
REQ-008 d_orig  out  1  raw (pre-NRZI) bit stream to the NRZI encoder.
REQ-009 pause  out  1  current bit period carries a stuffed zero.
REQ-010 flag_8  out  1  current bit period carries bit 7 of a byte.
REQ-011 eop  out  1  encoder drives SE0 (end of packet).
REQ-012 tx_active  out  1  a packet is in progress, EOP included.
REQ-013 underrun_err  out  1  one-cycle pulse: next byte was not available when required.

Function
REQ-014 Byte transfer occurs only on a cycle where byte_valid && byte_ready.
REQ-015 A bit-period counter runs 0..CLKS_PER_BIT-1 while tx_active; "tick" is the cycle it equals CLKS_PER_BIT-1; all serial outputs change only on the cycle after a tick or on packet start.
REQ-016 FSM states: IDLE, SHIFT, STUFF, EOP.
REQ-017 IDLE: byte_ready=1, d_orig=1, tx_active=0; on transfer, latch byte and last_byte, clear ones-count, go to SHIFT; bit 0 appears on d_orig the next cycle.
REQ-018 SHIFT: d_orig = current bit; a 1 increments the ones-count, a 0 clears it.
REQ-019 On the tick in SHIFT, if ones-count has reached 6, go to STUFF; the shift position does not advance.
REQ-020 STUFF: d_orig=0, pause=1 for exactly one bit period; ones-count cleared; then resume at the next data bit, or go to EOP if the stuffed bit followed bit 7 of the last byte.
REQ-021 The ones-count persists across byte boundaries within a packet.
REQ-022 flag_8=1 for the whole bit period of bit 7; it is 0 during a stuffed bit.
REQ-023 During SHIFT, byte_ready=1 only on the tick of bit 7 of a non-last byte.
REQ-024 On that tick, a transfer loads the next byte, and its bit 0 (or a stuff bit, if ones-count=6) follows with no gap.
REQ-025 If no transfer occurs on that tick, pulse underrun_err for one cycle and go to EOP; the stuff bit still precedes EOP if it is due.
REQ-026 If bit 7 of the last byte ends with no stuff due, go to EOP.
REQ-027 EOP: eop=1, d_orig=1 for 2 bit periods, then IDLE; byte_ready=0 throughout.
REQ-028 pause, flag_8 and eop are mutually exclusive.
REQ-029 byte_valid during EOP is ignored.

Reset
REQ-030 While rst=1: state=IDLE, counters=0, d_orig=1, pause=0, flag_8=0, eop=0, tx_active=0, underrun_err=0, byte_ready=0.
REQ-031 byte_ready=1 from the first cycle after rst deasserts.
REQ-032 Reset mid-packet aborts immediately with no EOP emitted.

Structure
REQ-033 A shared package usb_tx_pkg holds the FSM state enum, STUFF_LEN=6 and EOP_BITS=2.
REQ-034 One sub-module, bit_timer, provides the CLKS_PER_BIT counter and tick output; everything else is in tx_bit_stuffer.

Verification (CLKS_PER_BIT=8)
REQ-035 0x80, last -> d_orig 0,0,0,0,0,0,0,1 (8 clks each), flag_8 on the 8th bit, then eop 16 clks, then IDLE.
REQ-036 0xFF, last -> 1x6, stuffed 0 with pause=1, 1,1, then EOP; 9 data bit periods total.
REQ-037 0xE0 then 0x07, last -> ones run across the boundary; stuffed 0 after bit 2 of the second byte; no gap between bytes.
REQ-038 0xFC, last -> 0,0,1x6, then a stuffed 0 (pause=1) before eop.
REQ-039 0x55 non-last, byte_valid low at the bit-7 tick -> underrun_err one pulse, then eop 2 bit periods.
REQ-040 rst asserted at bit 3 of 0xAA -> next cycle all outputs at reset values, no eop; a new packet afterwards transmits normally.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// Shared definitions for the USB transmit bit-stuffing path.
package usb_tx_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StStuff,
        StEop
    } tx_state_e;

    // Consecutive ones that force a stuffed zero, and the EOP length in bit periods.
    localparam int unsigned STUFF_LEN = 6;
    localparam int unsigned EOP_BITS  = 2;

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while running and flags the last cycle.
module bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    output logic tick_o
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!run_i || cnt_q == CntMax) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = run_i && (cnt_q == CntMax);

endmodule

// File: rtl/tx_bit_stuffer.sv
// Serialises packet bytes LSB first, inserting a zero after six consecutive ones,
// and finishes each packet with an EOP.
module tx_bit_stuffer
    import usb_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_byte,
    input  logic       byte_valid,
    input  logic       last_byte,
    output logic       byte_ready,
    output logic       d_orig,
    output logic       pause,
    output logic       flag_8,
    output logic       eop,
    output logic       tx_active,
    output logic       underrun_err
);

    localparam int unsigned EopW = (EOP_BITS > 1) ? $clog2(EOP_BITS) : 1;
    localparam logic [EopW-1:0] EopMax = EopW'(EOP_BITS - 1);

    tx_state_e       state_q, state_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [2:0]      ones_q, ones_d;
    logic            last_q, last_d;
    logic            end_q, end_d;
    logic [EopW-1:0] eop_cnt_q, eop_cnt_d;
    logic            err_q, err_d;

    logic       tick;
    logic       cur_bit;
    logic       is_bit7;
    logic [2:0] ones_inc;
    logic       stuff_due;
    logic       xfer;
    logic       end_after;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .rst   (rst),
        .run_i (state_q != StIdle),
        .tick_o(tick)
    );

    assign cur_bit   = shreg_q[bit_idx_q];
    assign is_bit7   = (bit_idx_q == 3'd7);
    assign ones_inc  = cur_bit ? ones_q + 3'd1 : 3'd0;
    assign stuff_due = (ones_inc == 3'(STUFF_LEN));
    assign xfer      = byte_valid && byte_ready;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        ones_d    = ones_q;
        last_d    = last_q;
        end_d     = end_q;
        eop_cnt_d = '0;
        err_d     = 1'b0;
        end_after = 1'b0;

        case (state_q)
            StIdle: begin
                if (xfer) begin
                    shreg_d   = tx_byte;
                    last_d    = last_byte;
                    ones_d    = 3'd0;
                    bit_idx_d = 3'd0;
                    end_d     = 1'b0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                if (tick) begin
                    ones_d    = ones_inc;
                    // Position moves on now; a due stuff bit is emitted before it.
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (is_bit7) begin
                        if (xfer) begin
                            shreg_d = tx_byte;
                            last_d  = last_byte;
                        end else begin
                            end_after = 1'b1;
                            err_d     = !last_q;
                        end
                    end
                    if (stuff_due) begin
                        ones_d  = 3'd0;
                        end_d   = end_after;
                        state_d = StStuff;
                    end else begin
                        state_d = end_after ? StEop : StShift;
                    end
                end
            end
            StStuff: begin
                if (tick) begin
                    state_d = end_q ? StEop : StShift;
                end
            end
            StEop: begin
                eop_cnt_d = eop_cnt_q;
                if (tick) begin
                    if (eop_cnt_q == EopMax) begin
                        state_d = StIdle;
                    end else begin
                        eop_cnt_d = eop_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            ones_q    <= '0;
            last_q    <= 1'b0;
            end_q     <= 1'b0;
            eop_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            ones_q    <= ones_d;
            last_q    <= last_d;
            end_q     <= end_d;
            eop_cnt_q <= eop_cnt_d;
            err_q     <= err_d;
        end
    end

    // Outputs are forced to their idle values in the same cycle rst is seen.
    always_comb begin
        byte_ready   = 1'b0;
        d_orig       = 1'b1;
        pause        = 1'b0;
        flag_8       = 1'b0;
        eop          = 1'b0;
        tx_active    = 1'b0;
        underrun_err = 1'b0;
        if (!rst) begin
            tx_active    = (state_q != StIdle);
            underrun_err = err_q;
            case (state_q)
                StIdle:  byte_ready = 1'b1;
                StShift: begin
                    d_orig     = cur_bit;
                    flag_8     = is_bit7;
                    byte_ready = tick && is_bit7 && !last_q;
                end
                StStuff: begin
                    d_orig = 1'b0;
                    pause  = 1'b1;
                end
                StEop:   eop = 1'b1;
                default: d_orig = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_bit_stuffer.sv
// Directed bench for tx_bit_stuffer: packet table checked every cycle plus reset sequences.
module tb_tx_bit_stuffer;

    localparam int unsigned CLKS = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_byte = 8'h00;
    logic       byte_valid = 1'b0;
    logic       last_byte = 1'b0;
    logic       byte_ready, d_orig, pause, flag_8, eop, tx_active, underrun_err;

    tx_bit_stuffer #(
        .CLKS_PER_BIT(CLKS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_byte     (tx_byte),
        .byte_valid  (byte_valid),
        .last_byte   (last_byte),
        .byte_ready  (byte_ready),
        .d_orig      (d_orig),
        .pause       (pause),
        .flag_8      (flag_8),
        .eop         (eop),
        .tx_active   (tx_active),
        .underrun_err(underrun_err)
    );

    always #5 clk = ~clk;

    // exp: one char per bit period. '0'/'1' data, 'a'/'b' bit 7 = 0/1, 'S' stuffed zero, 'E' EOP.
    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        bit         last0;
        bit         has_next;
        bit         und;
        string      exp;
    } vec_t;

    vec_t vecs[7];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Packed order: {d_orig, pause, flag_8, eop, tx_active, byte_ready, underrun_err}
    localparam logic [6:0] OutsReset = 7'b1000000;
    localparam logic [6:0] OutsIdle  = 7'b1000010;

    function automatic logic [6:0] outs();
        return {d_orig, pause, flag_8, eop, tx_active, byte_ready, underrun_err};
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b required %b (d,pause,f8,eop,act,rdy,und)", name, act, req);
        end
    endtask

    task automatic run_vec(input int v);
        vec_t       t;
        int         first7;
        int         n;
        byte        sym;
        logic [6:0] req;
        t      = vecs[v];
        n      = t.exp.len();
        first7 = -1;
        for (int i = 0; i < n; i++) begin
            if (first7 < 0 && (t.exp[i] == "a" || t.exp[i] == "b")) first7 = i;
        end
        @(negedge clk);
        check($sformatf("v%0d idle_before", v), outs(), OutsIdle);
        tx_byte    = t.b0;
        last_byte  = t.last0;
        byte_valid = 1'b1;
        for (int p = 0; p < n; p++) begin
            for (int c = 0; c < int'(CLKS); c++) begin
                @(negedge clk);
                if (p == 0 && c == 0) begin
                    tx_byte   = t.b1;
                    last_byte = 1'b1;
                end
                sym    = t.exp[p];
                req[6] = (sym == "1" || sym == "b" || sym == "E");
                req[5] = (sym == "S");
                req[4] = (sym == "a" || sym == "b");
                req[3] = (sym == "E");
                req[2] = 1'b1;
                req[1] = (p == first7) && (c == int'(CLKS) - 1) && !t.last0;
                req[0] = t.und && (p == first7 + 1) && (c == 0);
                check($sformatf("v%0d p%0d c%0d", v, p, c), outs(), req);
                // Offer a byte during EOP too; it must be ignored.
                if (sym == "E") byte_valid = !(p == n - 1 && c == int'(CLKS) - 1);
                else            byte_valid = t.has_next && (p <= first7);
            end
        end
        @(negedge clk);
        check($sformatf("v%0d idle_after", v), outs(), OutsIdle);
    endtask

    initial begin
        vecs[0] = '{8'h80, 8'h00, 1'b1, 1'b0, 1'b0, "0000000bEE"};
        vecs[1] = '{8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, "111111S1bEE"};
        vecs[2] = '{8'hE0, 8'h07, 1'b0, 1'b1, 1'b0, "0000011b111S0000aEE"};
        vecs[3] = '{8'hFC, 8'h00, 1'b1, 1'b0, 1'b0, "0011111bSEE"};
        vecs[4] = '{8'h55, 8'h00, 1'b0, 1'b0, 1'b1, "1010101aEE"};
        vecs[5] = '{8'hFC, 8'h00, 1'b0, 1'b0, 1'b1, "0011111bSEE"};
        vecs[6] = '{8'hFC, 8'h01, 1'b0, 1'b1, 1'b0, "0011111bS1000000aEE"};

        repeat (3) @(negedge clk);
        check("reset_held", outs(), OutsReset);
        rst = 1'b0;
        #1;
        check("ready_after_reset", outs(), OutsIdle);

        for (int v = 0; v < 7; v++) run_vec(v);

        // Abort 0xAA mid-packet while bit 3 (a one) is on the line.
        @(negedge clk);
        tx_byte    = 8'hAA;
        last_byte  = 1'b1;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
        repeat (3 * CLKS + 3) @(negedge clk);
        check("abort_bit3", outs(), 7'b1000100);
        rst = 1'b1;
        #1;
        check("abort_rst_now", outs(), OutsReset);
        @(negedge clk);
        check("abort_rst_next", outs(), OutsReset);
        rst = 1'b0;
        for (int i = 0; i < int'(2 * CLKS); i++) begin
            @(negedge clk);
            check($sformatf("abort_no_eop c%0d", i), outs(), OutsIdle);
        end
        run_vec(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
